// File: rtl/rst_seq_pkg.sv
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared types and constants for the strap reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_pkg;

    // Sequencer states, 3-bit encoding; codes 5..7 are illegal.
    typedef enum logic [2:0] {
        ST_PRST   = 3'd0,
        ST_CLKOFF = 3'd1,
        ST_CLKON  = 3'd2,
        ST_RUN    = 3'd3,
        ST_SOFT   = 3'd4
    } rst_seq_state_e;

    // Default delay constants.
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_P_RST_CYC   = 16;
    localparam int DEF_CLK_ENB_DLY = 8;
    localparam int DEF_S_RST_DLY   = 8;

    // Number of cycles spent in ST_SOFT before replaying the clock sequence.
    localparam int SOFT_RST_CYC    = 2;

    // Width of the optional soft-reboot counter.
    localparam int BOOT_CNT_W      = 8;

    // Output decode: {p_reset_n, clk_enb, s_reset_n}. Illegal codes decode to
    // the full-reset pattern.
    function automatic logic [2:0] seq_out_decode(input rst_seq_state_e st);
        logic [2:0] v;
        v = 3'b000;
        case (st)
            ST_PRST:   v = 3'b000;
            ST_CLKOFF: v = 3'b100;
            ST_CLKON:  v = 3'b110;
            ST_RUN:    v = 3'b111;
            ST_SOFT:   v = 3'b110;
            default:   v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rst_seq_sync2.sv
// ============================================================================
// Module      : rst_seq_sync2
// Description : Two-flop synchroniser with asynchronous active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/strap_rst_seq.sv
// ============================================================================
// Module      : strap_rst_seq
// Description : Reset sequencer between external reset and the strap/sticky
//               register block. Orders p_reset_n, clk_enb and s_reset_n
//               release and replays the clk_enb/s_reset_n part on a
//               soft-reboot request (strap_sticky[31]).
//               Optional macro RST_SEQ_BOOT_CNT_EN adds a saturating
//               soft-reboot counter on port boot_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module strap_rst_seq
    import rst_seq_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int P_RST_CYC   = DEF_P_RST_CYC,
    parameter int CLK_ENB_DLY = DEF_CLK_ENB_DLY,
    parameter int S_RST_DLY   = DEF_S_RST_DLY
) (
    input  logic                  clk,
    input  logic                  e_reset_n,
    input  logic                  soft_reboot_req,
    output logic                  p_reset_n,
    output logic                  clk_enb,
    output logic                  s_reset_n,
    output logic                  seq_busy
`ifdef RST_SEQ_BOOT_CNT_EN
    ,
    output logic [BOOT_CNT_W-1:0] boot_cnt
`endif
);

    // Terminal counter values: each delay state lasts exactly its parameter.
    localparam logic [CNT_W-1:0] C_PRST_LAST   = CNT_W'(P_RST_CYC - 1);
    localparam logic [CNT_W-1:0] C_CLKOFF_LAST = CNT_W'(CLK_ENB_DLY - 1);
    localparam logic [CNT_W-1:0] C_CLKON_LAST  = CNT_W'(S_RST_DLY - 1);
    localparam logic [CNT_W-1:0] C_SOFT_LAST   = CNT_W'(SOFT_RST_CYC - 1);

    rst_seq_state_e   r_state;
    rst_seq_state_e   w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_req_sync;
    logic             r_req_sync_d;
    logic [2:0]       w_next_out;

    rst_seq_sync2 u_req_sync (
        .clk   (clk),
        .rst_n (e_reset_n),
        .d     (soft_reboot_req),
        .q     (w_req_sync)
    );

    // Delayed copy of the synchronised request for rising-edge detection.
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            r_req_sync_d <= 1'b0;
        end else begin
            r_req_sync_d <= w_req_sync;
        end
    end

    // Next-state and delay-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_PRST: begin
                if (r_cnt == C_PRST_LAST) begin
                    w_next_state = ST_CLKOFF;
                end
            end
            ST_CLKOFF: begin
                if (r_cnt == C_CLKOFF_LAST) begin
                    w_next_state = ST_CLKON;
                end
            end
            ST_CLKON: begin
                // A request still asserted here parks the sequence with the
                // counter held, so a stuck bit 31 cannot cause a reboot loop.
                if ((r_cnt == C_CLKON_LAST) && !w_req_sync) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_req_sync && !r_req_sync_d) begin
                    w_next_state = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (r_cnt == C_SOFT_LAST) begin
                    w_next_state = ST_CLKOFF;
                end
            end
            default: begin
                w_next_state = ST_PRST;
            end
        endcase

        if (w_next_state != r_state) begin
            w_next_cnt = '0;
        end else if ((r_state == ST_PRST) || (r_state == ST_CLKOFF) ||
                     (r_state == ST_SOFT) ||
                     ((r_state == ST_CLKON) && (r_cnt != C_CLKON_LAST))) begin
            w_next_cnt = r_cnt + 1'b1;
        end
    end

    assign w_next_out = seq_out_decode(w_next_state);

    // State, counter and registered output decode.
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            r_state   <= ST_PRST;
            r_cnt     <= '0;
            p_reset_n <= 1'b0;
            clk_enb   <= 1'b0;
            s_reset_n <= 1'b0;
            seq_busy  <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            p_reset_n <= w_next_out[2];
            clk_enb   <= w_next_out[1];
            s_reset_n <= w_next_out[0];
            seq_busy  <= (w_next_state != ST_RUN);
        end
    end

`ifdef RST_SEQ_BOOT_CNT_EN
    // Saturating count of RUN -> SOFT transitions, cleared only by e_reset_n.
    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            boot_cnt <= '0;
        end else if ((r_state == ST_RUN) && (w_next_state == ST_SOFT) &&
                     (boot_cnt != {BOOT_CNT_W{1'b1}})) begin
            boot_cnt <= boot_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_strap_rst_seq.sv
// ============================================================================
// Module      : tb_strap_rst_seq
// Description : Directed self-checking bench for strap_rst_seq. Drives a
//               default-parameter instance and a minimum-delay instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_strap_rst_seq;

    logic       clk;
    logic       e_reset_n;
    logic       req;
    logic       req_min;
    logic       p_reset_n, clk_enb, s_reset_n, seq_busy;
    logic       p_reset_n_m, clk_enb_m, s_reset_n_m, seq_busy_m;
`ifdef RST_SEQ_BOOT_CNT_EN
    logic [7:0] boot_cnt;
    logic [7:0] boot_cnt_m;
`endif

    int n_checks = 0;
    int n_errors = 0;

    strap_rst_seq u_dut (
        .clk             (clk),
        .e_reset_n       (e_reset_n),
        .soft_reboot_req (req),
        .p_reset_n       (p_reset_n),
        .clk_enb         (clk_enb),
        .s_reset_n       (s_reset_n),
`ifdef RST_SEQ_BOOT_CNT_EN
        .boot_cnt        (boot_cnt),
`endif
        .seq_busy        (seq_busy)
    );

    strap_rst_seq #(
        .CNT_W       (8),
        .P_RST_CYC   (1),
        .CLK_ENB_DLY (1),
        .S_RST_DLY   (1)
    ) u_dut_min (
        .clk             (clk),
        .e_reset_n       (e_reset_n),
        .soft_reboot_req (req_min),
        .p_reset_n       (p_reset_n_m),
        .clk_enb         (clk_enb_m),
        .s_reset_n       (s_reset_n_m),
`ifdef RST_SEQ_BOOT_CNT_EN
        .boot_cnt        (boot_cnt_m),
`endif
        .seq_busy        (seq_busy_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vectors {p_reset_n, clk_enb, s_reset_n, seq_busy}.
    localparam logic [3:0] V_PRST   = 4'b0001;
    localparam logic [3:0] V_CLKOFF = 4'b1001;
    localparam logic [3:0] V_CLKON  = 4'b1101;
    localparam logic [3:0] V_SOFT   = 4'b1101;
    localparam logic [3:0] V_RUN    = 4'b1110;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, p_reset_n, clk_enb, s_reset_n, seq_busy}, {28'd0, exp});
    endtask

    task automatic chk_min(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, p_reset_n_m, clk_enb_m, s_reset_n_m, seq_busy_m}, {28'd0, exp});
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_boot(input string tag, input int exp);
`ifdef RST_SEQ_BOOT_CNT_EN
        chk(tag, {24'd0, boot_cnt}, exp[31:0]);
`else
        if (exp < 0) $display("unused %s", tag);
`endif
    endtask

    // One complete soft reboot from ST_RUN, bounded wait for return to RUN.
    task automatic soft_reboot(input string tag);
        int k;
        @(negedge clk) req = 1'b1;
        tick(3);
        chk_out(tag, V_SOFT);
        @(negedge clk) req = 1'b0;
        k = 0;
        while (seq_busy && k < 40) begin
            tick(1);
            k++;
        end
        chk({tag, "_idle"}, {31'd0, seq_busy}, 32'd0);
    endtask

    initial begin
        e_reset_n = 1'b0;
        req       = 1'b0;
        req_min   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", V_PRST);
        chk_min("reset_min", V_PRST);
        chk_boot("reset_boot", 0);

        // Power-on: edge k is the k-th rising edge after release
        @(negedge clk) e_reset_n = 1'b1;
        #1 chk_out("rel_e0", V_PRST);
        tick(1);  chk_min("min_e1", V_CLKOFF); chk_out("po_e1", V_PRST);
        tick(1);  chk_min("min_e2", V_CLKON);
        tick(1);  chk_min("min_e3", V_RUN);
        tick(12); chk_out("po_e15", V_PRST);
        tick(1);  chk_out("po_e16", V_CLKOFF);
        tick(7);  chk_out("po_e23", V_CLKOFF);
        tick(1);  chk_out("po_e24", V_CLKON);
        tick(7);  chk_out("po_e31", V_CLKON);
        tick(1);  chk_out("po_e32", V_RUN);

        // Soft reboot: request rises mid-cycle (cycle 1); s_reset_n low
        // from the 4th cycle, i.e. after the 3rd rising edge.
        tick(2);
        @(negedge clk) req = 1'b1;
        tick(2);  chk_out("sr_e2", V_RUN);
        tick(1);  chk_out("sr_e3_soft", V_SOFT);
        tick(1);  chk_out("sr_e4_soft", V_SOFT);
        tick(1);  chk_out("sr_e5_clkoff", V_CLKOFF);
        @(negedge clk) req = 1'b0;
        tick(7);  chk_out("sr_e12", V_CLKOFF);
        tick(1);  chk_out("sr_e13_clkon", V_CLKON);
        tick(7);  chk_out("sr_e20", V_CLKON);
        tick(1);  chk_out("sr_e21_run", V_RUN);
        chk_boot("sr_boot", 1);

        // Stuck request: parks in ST_CLKON until the request drops
        tick(2);
        @(negedge clk) req = 1'b1;
        tick(3);  chk_out("st_soft", V_SOFT);
        tick(27); chk_out("st_parked", V_CLKON);
        @(negedge clk) req = 1'b0;
        tick(2);  chk_out("st_rel2", V_CLKON);
        tick(1);  chk_out("st_rel3", V_RUN);
        tick(10); chk_out("st_no_loop", V_RUN);
        chk_boot("st_boot", 2);

        // Mid-sequence reset while in ST_CLKON
        @(negedge clk) e_reset_n = 1'b0;
        tick(2);
        @(negedge clk) e_reset_n = 1'b1;
        tick(26); chk_out("mr_clkon", V_CLKON);
        #2 e_reset_n = 1'b0;
        #1 chk_out("mr_async", V_PRST);
        chk_min("mr_async_min", V_PRST);
        chk_boot("mr_boot", 0);
        tick(2);  chk_out("mr_hold", V_PRST);
        @(negedge clk) e_reset_n = 1'b1;
        tick(15); chk_out("mr_e15", V_PRST);
        tick(1);  chk_out("mr_e16", V_CLKOFF);
        tick(8);  chk_out("mr_e24", V_CLKON);
        tick(7);  chk_out("mr_e31", V_CLKON);
        tick(1);  chk_out("mr_e32", V_RUN);

        // Request held high across reset release is ignored
        @(negedge clk) begin
            e_reset_n = 1'b0;
            req       = 1'b1;
        end
        tick(2);
        @(negedge clk) e_reset_n = 1'b1;
        tick(32); chk_out("hr_e32_guard", V_CLKON);
        tick(20); chk_out("hr_e52_guard", V_CLKON);
        @(negedge clk) req = 1'b0;
        tick(2);  chk_out("hr_rel2", V_CLKON);
        tick(1);  chk_out("hr_rel3", V_RUN);
        tick(10); chk_out("hr_no_reboot", V_RUN);
        chk_boot("hr_boot", 0);
        chk_min("min_idle", V_RUN);

`ifdef RST_SEQ_BOOT_CNT_EN
        // Saturation of the reboot counter
        for (int i = 0; i < 260; i++) begin
            soft_reboot("sat");
            if (i == 254) chk_boot("sat_255", 255);
        end
        chk_boot("sat_hold", 255);
`else
        soft_reboot("plain");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
